// File: rtl/mem_mp_tagged.sv
// Shared word array behind NUM_PORTS round-robin request channels with tagged, fixed-latency completions.
// Optional per-port accept/reject statistics when MEM_STATS_EN is defined.
module mem_mp_tagged #(
  parameter int NUM_PORTS       = 2,
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int DEPTH           = 16384,
  parameter int LATENCY         = 4,
  parameter int TAG_W           = 4,
  parameter int MAX_OUTSTANDING = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_PORTS*ADDR_W-1:0]   proc2mem_addr,
  input  logic [NUM_PORTS*DATA_W-1:0]   proc2mem_data,
  input  logic [NUM_PORTS*2-1:0]        proc2mem_command,
  output logic [NUM_PORTS*TAG_W-1:0]    mem2proc_response,
  output logic [NUM_PORTS*DATA_W-1:0]   mem2proc_data,
  output logic [NUM_PORTS*TAG_W-1:0]    mem2proc_tag
`ifdef MEM_STATS_EN
  ,
  output logic [NUM_PORTS*32-1:0]       stat_accept_cnt,
  output logic [NUM_PORTS*32-1:0]       stat_reject_cnt
`endif
);

  localparam int IDX_W  = ADDR_W - 2;
  localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W  = $clog2(MAX_OUTSTANDING + 1);
  localparam int PTR_W  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam logic [IDX_W:0]     DEPTH_C = (IDX_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0]   MAX_C   = CNT_W'(MAX_OUTSTANDING);
  localparam logic [TAG_W-1:0]   TAG_ONE = TAG_W'(1);
  localparam logic [1:0]         CMD_LOAD  = 2'b01;
  localparam logic [1:0]         CMD_STORE = 2'b10;

  logic [DATA_W-1:0] unified_memory [0:DEPTH-1];

  logic [NUM_PORTS-1:0] req_s;
  logic [NUM_PORTS-1:0] grant_s;
  logic [NUM_PORTS-1:0] accept_s;
  logic [NUM_PORTS-1:0] in_range_s;
  logic [NUM_PORTS-1:0] completing_s;
  logic [IDX_W-1:0]     widx_s [NUM_PORTS];
  logic                 found_s;
  logic [PTR_W-1:0]     gidx_s;
  logic [PTR_W-1:0]     rr_r;
  logic [TAG_W-1:0]     tag_r [NUM_PORTS];
  logic [CNT_W-1:0]     cnt_r [NUM_PORTS];
  logic [TAG_W-1:0]     pipe_tag_r  [NUM_PORTS][LATENCY];
  logic [DATA_W-1:0]    pipe_data_r [NUM_PORTS][LATENCY];
  logic [MEM_AW-1:0]    mem_idx_s;
  logic [DATA_W-1:0]    wdata_s;
  logic [DATA_W-1:0]    load_data_s;
  logic                 mem_acc_s;
  logic                 mem_store_s;
  logic                 unused_addr_s;

  // Per-port request decode, range check and completion-present flag
  always_comb begin
    req_s         = '0;
    in_range_s    = '0;
    completing_s  = '0;
    unused_addr_s = 1'b0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      req_s[p]        = (proc2mem_command[2*p +: 2] == CMD_LOAD) ||
                        (proc2mem_command[2*p +: 2] == CMD_STORE);
      widx_s[p]       = proc2mem_addr[p*ADDR_W+2 +: IDX_W];
      in_range_s[p]   = {1'b0, widx_s[p]} < DEPTH_C;
      completing_s[p] = pipe_tag_r[p][LATENCY-1] != '0;
      unused_addr_s   = unused_addr_s ^ (^proc2mem_addr[p*ADDR_W +: 2]);
    end
  end

  // Round-robin search for the first requester at or after the pointer
  always_comb begin
    grant_s = '0;
    gidx_s  = '0;
    found_s = 1'b0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (!found_s && req_s[(int'(rr_r) + k) % NUM_PORTS]) begin
        found_s = 1'b1;
        grant_s[(int'(rr_r) + k) % NUM_PORTS] = 1'b1;
        gidx_s  = PTR_W'((int'(rr_r) + k) % NUM_PORTS);
      end else begin
        found_s = found_s;
      end
    end
  end

  // A completion leaving this cycle frees its slot for a same-cycle accept
  always_comb begin
    accept_s          = '0;
    mem2proc_response = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      accept_s[p] = grant_s[p] && in_range_s[p] && !rst &&
                    (completing_s[p] || (cnt_r[p] < MAX_C));
      if (accept_s[p]) begin
        mem2proc_response[p*TAG_W +: TAG_W] = tag_r[p];
      end else begin
        mem2proc_response[p*TAG_W +: TAG_W] = '0;
      end
    end
  end

  // Single shared array port, steered by the grantee
  always_comb begin
    mem_acc_s   = |accept_s;
    mem_idx_s   = MEM_AW'(widx_s[gidx_s]);
    wdata_s     = proc2mem_data[gidx_s*DATA_W +: DATA_W];
    mem_store_s = proc2mem_command[gidx_s*2 +: 2] == CMD_STORE;
    if (mem_store_s) begin
      load_data_s = '0;
    end else begin
      load_data_s = unified_memory[mem_idx_s];
    end
  end

  // Array write; contents survive reset
  always_ff @(posedge clk) begin
    if (mem_acc_s && mem_store_s) begin
      unified_memory[mem_idx_s] <= wdata_s;
    end
  end

  // Arbiter pointer, tag counters, outstanding counters and completion pipes
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_r <= '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
        tag_r[p] <= TAG_ONE;
        cnt_r[p] <= '0;
        for (int s = 0; s < LATENCY; s++) begin
          pipe_tag_r[p][s]  <= '0;
          pipe_data_r[p][s] <= '0;
        end
      end
    end else begin
      if (|grant_s) begin
        rr_r <= (int'(gidx_s) + 1 >= NUM_PORTS) ? '0 : gidx_s + PTR_W'(1);
      end
      for (int p = 0; p < NUM_PORTS; p++) begin
        for (int s = LATENCY - 1; s > 0; s--) begin
          pipe_tag_r[p][s]  <= pipe_tag_r[p][s-1];
          pipe_data_r[p][s] <= pipe_data_r[p][s-1];
        end
        pipe_tag_r[p][0]  <= accept_s[p] ? tag_r[p] : '0;
        pipe_data_r[p][0] <= accept_s[p] ? load_data_s : '0;
        if (accept_s[p]) begin
          tag_r[p] <= (tag_r[p] == '1) ? TAG_ONE : tag_r[p] + TAG_ONE;
        end
        case ({accept_s[p], completing_s[p]})
          2'b10:   cnt_r[p] <= cnt_r[p] + CNT_W'(1);
          2'b01:   cnt_r[p] <= cnt_r[p] - CNT_W'(1);
          default: cnt_r[p] <= cnt_r[p];
        endcase
      end
    end
  end

  // Completion outputs straight from the last pipe stage
  always_comb begin
    mem2proc_tag  = '0;
    mem2proc_data = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      mem2proc_tag[p*TAG_W +: TAG_W]    = pipe_tag_r[p][LATENCY-1];
      mem2proc_data[p*DATA_W +: DATA_W] = pipe_data_r[p][LATENCY-1];
    end
  end

`ifdef MEM_STATS_EN
  logic [31:0] acc_cnt_r [NUM_PORTS];
  logic [31:0] rej_cnt_r [NUM_PORTS];

  // Saturating accept/reject counters
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        acc_cnt_r[p] <= '0;
        rej_cnt_r[p] <= '0;
      end
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (accept_s[p] && (acc_cnt_r[p] != '1)) begin
          acc_cnt_r[p] <= acc_cnt_r[p] + 32'd1;
        end
        if (req_s[p] && !accept_s[p] && (rej_cnt_r[p] != '1)) begin
          rej_cnt_r[p] <= rej_cnt_r[p] + 32'd1;
        end
      end
    end
  end

  // Flatten statistics onto the output buses
  always_comb begin
    stat_accept_cnt = '0;
    stat_reject_cnt = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      stat_accept_cnt[p*32 +: 32] = acc_cnt_r[p];
      stat_reject_cnt[p*32 +: 32] = rej_cnt_r[p];
    end
  end
`endif

endmodule

// File: tb/tb_mem_mp_tagged.sv
// Directed table-driven bench for mem_mp_tagged (2 ports, LATENCY 4, MAX_OUTSTANDING 3, TAG_W 4).
module tb_mem_mp_tagged;
  localparam int NP = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TW = 4;
  localparam logic [1:0] CN = 2'b00;
  localparam logic [1:0] CL = 2'b01;
  localparam logic [1:0] CS = 2'b10;

  logic clk = 1'b0;
  logic rst;
  logic [NP*AW-1:0] addr;
  logic [NP*DW-1:0] wdata;
  logic [NP*2-1:0]  cmd;
  logic [NP*TW-1:0] resp;
  logic [NP*DW-1:0] rdata;
  logic [NP*TW-1:0] rtag;
`ifdef MEM_STATS_EN
  logic [NP*32-1:0] st_acc;
  logic [NP*32-1:0] st_rej;
`endif

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_mp_tagged dut (
    .clk               (clk),
    .rst               (rst),
    .proc2mem_addr     (addr),
    .proc2mem_data     (wdata),
    .proc2mem_command  (cmd),
    .mem2proc_response (resp),
    .mem2proc_data     (rdata),
    .mem2proc_tag      (rtag)
`ifdef MEM_STATS_EN
    ,
    .stat_accept_cnt   (st_acc),
    .stat_reject_cnt   (st_rej)
`endif
  );

  typedef struct {
    logic [1:0]  c0; logic [31:0] a0; logic [31:0] d0;
    logic [1:0]  c1; logic [31:0] a1; logic [31:0] d1;
    logic [3:0]  r0; logic [3:0]  r1;
    logic [3:0]  t0; logic [31:0] q0;
    logic [3:0]  t1; logic [31:0] q1;
  } vec_t;

  vec_t tv [0:23];
  vec_t rt [0:15];

  function automatic vec_t mk(input logic [1:0] c0, input logic [31:0] a0, input logic [31:0] d0,
                              input logic [1:0] c1, input logic [31:0] a1, input logic [31:0] d1,
                              input logic [3:0] r0, input logic [3:0] r1,
                              input logic [3:0] t0, input logic [31:0] q0,
                              input logic [3:0] t1, input logic [31:0] q1);
    vec_t v;
    v.c0 = c0; v.a0 = a0; v.d0 = d0; v.c1 = c1; v.a1 = a1; v.d1 = d1;
    v.r0 = r0; v.r1 = r1; v.t0 = t0; v.q0 = q0; v.t1 = t1; v.q1 = q1;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drives one cycle of stimulus, checks outputs at the falling edge, returns just after the next rising edge
  task automatic apply(input vec_t v, input string name);
    cmd   = {v.c1, v.c0};
    addr  = {v.a1, v.a0};
    wdata = {v.d1, v.d0};
    @(negedge clk);
    chk($sformatf("%s.resp0", name), 32'(resp[3:0]),   32'(v.r0));
    chk($sformatf("%s.resp1", name), 32'(resp[7:4]),   32'(v.r1));
    chk($sformatf("%s.tag0", name),  32'(rtag[3:0]),   32'(v.t0));
    chk($sformatf("%s.data0", name), rdata[31:0],      v.q0);
    chk($sformatf("%s.tag1", name),  32'(rtag[7:4]),   32'(v.t1));
    chk($sformatf("%s.data1", name), rdata[63:32],     v.q1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t v;
    logic [3:0] exp_tag;
    logic [3:0] hist [0:19];
    logic [3:0] er;
    logic [3:0] et;

    // Basic load/store, round-robin, out-of-range, alternating grants
    tv[0]  = mk(CN, 32'h0,     32'h0,        CN, 32'h0,  32'h0,        4'd0, 4'd0, 4'd0, 32'h0,        4'd0, 32'h0);
    tv[1]  = mk(CS, 32'h40,    32'hDEADBEEF, CN, 32'h0,  32'h0,        4'd1, 4'd0, 4'd0, 32'h0,        4'd0, 32'h0);
    tv[2]  = mk(CL, 32'h40,    32'h0,        CN, 32'h0,  32'h0,        4'd2, 4'd0, 4'd0, 32'h0,        4'd0, 32'h0);
    tv[3]  = mk(CN, 32'h0,     32'h0,        CS, 32'h20, 32'h12345678, 4'd0, 4'd1, 4'd0, 32'h0,        4'd0, 32'h0);
    tv[4]  = mk(CN, 32'h0,     32'h0,        CL, 32'h20, 32'h0,        4'd0, 4'd2, 4'd0, 32'h0,        4'd0, 32'h0);
    tv[5]  = mk(CN, 32'h0,     32'h0,        CN, 32'h0,  32'h0,        4'd0, 4'd0, 4'd1, 32'h0,        4'd0, 32'h0);
    tv[6]  = mk(CN, 32'h0,     32'h0,        CN, 32'h0,  32'h0,        4'd0, 4'd0, 4'd2, 32'hDEADBEEF, 4'd0, 32'h0);
    tv[7]  = mk(CL, 32'h10000, 32'h0,        CN, 32'h0,  32'h0,        4'd0, 4'd0, 4'd0, 32'h0,        4'd1, 32'h0);
    tv[8]  = mk(CN, 32'h0,     32'h0,        CN, 32'h0,  32'h0,        4'd0, 4'd0, 4'd0, 32'h0,        4'd2, 32'h12345678);
    tv[9]  = mk(CN, 32'h0,     32'h0,        CN, 32'h0,  32'h0,        4'd0, 4'd0, 4'd0, 32'h0,        4'd0, 32'h0);
    tv[10] = tv[9];
    tv[11] = tv[9];
    tv[12] = mk(CL, 32'h40,    32'h0,        CL, 32'h20, 32'h0,        4'd0, 4'd3, 4'd0, 32'h0,        4'd0, 32'h0);
    tv[13] = mk(CL, 32'h40,    32'h0,        CL, 32'h20, 32'h0,        4'd3, 4'd0, 4'd0, 32'h0,        4'd0, 32'h0);
    tv[14] = mk(CL, 32'h40,    32'h0,        CL, 32'h20, 32'h0,        4'd0, 4'd4, 4'd0, 32'h0,        4'd0, 32'h0);
    tv[15] = mk(CL, 32'h40,    32'h0,        CL, 32'h20, 32'h0,        4'd4, 4'd0, 4'd0, 32'h0,        4'd0, 32'h0);
    tv[16] = mk(CL, 32'h40,    32'h0,        CL, 32'h20, 32'h0,        4'd0, 4'd5, 4'd0, 32'h0,        4'd3, 32'h12345678);
    tv[17] = mk(CL, 32'h40,    32'h0,        CL, 32'h20, 32'h0,        4'd5, 4'd0, 4'd3, 32'hDEADBEEF, 4'd0, 32'h0);
    tv[18] = mk(CL, 32'h40,    32'h0,        CL, 32'h20, 32'h0,        4'd0, 4'd6, 4'd0, 32'h0,        4'd4, 32'h12345678);
    tv[19] = mk(CL, 32'h40,    32'h0,        CL, 32'h20, 32'h0,        4'd6, 4'd0, 4'd4, 32'hDEADBEEF, 4'd0, 32'h0);
    tv[20] = mk(CN, 32'h0,     32'h0,        CN, 32'h0,  32'h0,        4'd0, 4'd0, 4'd0, 32'h0,        4'd5, 32'h12345678);
    tv[21] = mk(CN, 32'h0,     32'h0,        CN, 32'h0,  32'h0,        4'd0, 4'd0, 4'd5, 32'hDEADBEEF, 4'd0, 32'h0);
    tv[22] = mk(CN, 32'h0,     32'h0,        CN, 32'h0,  32'h0,        4'd0, 4'd0, 4'd0, 32'h0,        4'd6, 32'h12345678);
    tv[23] = mk(CN, 32'h0,     32'h0,        CN, 32'h0,  32'h0,        4'd0, 4'd0, 4'd6, 32'hDEADBEEF, 4'd0, 32'h0);

    // Reset with two loads in flight, then recovery and out-of-range store aliasing word 0
    rt[0]  = mk(CL, 32'h40,    32'h0,        CN, 32'h0, 32'h0, 4'd4, 4'd0, 4'd0, 32'h0,        4'd0, 32'h0);
    rt[1]  = mk(CL, 32'h40,    32'h0,        CN, 32'h0, 32'h0, 4'd5, 4'd0, 4'd0, 32'h0,        4'd0, 32'h0);
    rt[2]  = mk(CN, 32'h0,     32'h0,        CN, 32'h0, 32'h0, 4'd0, 4'd0, 4'd0, 32'h0,        4'd0, 32'h0);
    for (int i = 3; i < 8; i++) rt[i] = rt[2];
    rt[8]  = mk(CS, 32'h0,     32'hA5A5A5A5, CN, 32'h0, 32'h0, 4'd1, 4'd0, 4'd0, 32'h0,        4'd0, 32'h0);
    rt[9]  = mk(CS, 32'h10000, 32'hFFFFFFFF, CN, 32'h0, 32'h0, 4'd0, 4'd0, 4'd0, 32'h0,        4'd0, 32'h0);
    rt[10] = mk(CL, 32'h40,    32'h0,        CN, 32'h0, 32'h0, 4'd2, 4'd0, 4'd0, 32'h0,        4'd0, 32'h0);
    rt[11] = mk(CL, 32'h0,     32'h0,        CN, 32'h0, 32'h0, 4'd3, 4'd0, 4'd0, 32'h0,        4'd0, 32'h0);
    rt[12] = mk(CN, 32'h0,     32'h0,        CN, 32'h0, 32'h0, 4'd0, 4'd0, 4'd1, 32'h0,        4'd0, 32'h0);
    rt[13] = rt[2];
    rt[14] = mk(CN, 32'h0,     32'h0,        CN, 32'h0, 32'h0, 4'd0, 4'd0, 4'd2, 32'hDEADBEEF, 4'd0, 32'h0);
    rt[15] = mk(CN, 32'h0,     32'h0,        CN, 32'h0, 32'h0, 4'd0, 4'd0, 4'd3, 32'hA5A5A5A5, 4'd0, 32'h0);

    rst   = 1'b1;
    cmd   = '0;
    addr  = '0;
    wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 24; i++) apply(tv[i], $sformatf("tv%0d", i));

    // Port 0 loads every cycle: 3-of-4 accept pattern and tag wrap 15 -> 1
    exp_tag = 4'd7;
    for (int i = 0; i < 20; i++) begin
      if ((i < 16) && ((i % 4) != 3)) begin
        er = exp_tag;
        exp_tag = (exp_tag == 4'd15) ? 4'd1 : exp_tag + 4'd1;
      end else begin
        er = 4'd0;
      end
      hist[i] = er;
      et = (i >= 4) ? hist[i-4] : 4'd0;
      v = mk((i < 16) ? CL : CN, 32'h40, 32'h0, CN, 32'h0, 32'h0,
             er, 4'd0, et, (et != 4'd0) ? 32'hDEADBEEF : 32'h0, 4'd0, 32'h0);
      apply(v, $sformatf("stream%0d", i));
    end

    for (int i = 0; i < 16; i++) begin
      if (i == 2) begin
        rst = 1'b1;
        cmd = '0;
        @(negedge clk);
        chk("rst.resp", 32'(resp), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
`ifdef MEM_STATS_EN
        chk("stat.acc", st_acc[31:0] | st_acc[63:32], 32'h0);
        chk("stat.rej", st_rej[31:0] | st_rej[63:32], 32'h0);
`endif
      end
      apply(rt[i], $sformatf("rt%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
